// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encodings,
// default control width and the control-field layout callers pack into in_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned CTRL_W_DEF = 8;

  // Control payload bit layout (LSB first)
  localparam int unsigned CTRL_REG_WRITE_BIT  = 0;
  localparam int unsigned CTRL_MEM_TO_REG_BIT = 1;
  localparam int unsigned CTRL_MEM_WRITE_BIT  = 2;
  localparam int unsigned CTRL_MEM_READ_BIT   = 3;
  localparam int unsigned CTRL_EXT_MODE_LSB   = 4;
  localparam int unsigned CTRL_EXT_MODE_W     = 2;
  localparam int unsigned CTRL_HILO_WRITE_BIT = 6;
  localparam int unsigned CTRL_LINK_BIT       = 7;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with load enable and asynchronous clear.
module pipe_skid_slot #(
  parameter int unsigned W = 40
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture payload on load; cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating
// stall counter. Define PIPE_STAGE_SKID_EN for a 2-entry skid build with a
// registered in_ready; otherwise a single register with combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = CTRL_W_DEF,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  localparam int unsigned PAY_W = DATA_W + CTRL_W;

  state_e           state;
  state_e           state_nxt;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] in_pay;

  assign in_pay    = {in_ctrl, in_data};
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q[DATA_W-1:0];
  // A bubble must never carry live control bits
  assign out_ctrl  = out_valid ? main_q[PAY_W-1:DATA_W] : '0;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  pipe_skid_slot #(.W(PAY_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .d       (main_d),
    .q       (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN

  logic             skid_load;
  logic [PAY_W-1:0] skid_q;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  pipe_skid_slot #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .d       (in_pay),
    .q       (skid_q)
  );

  // Occupancy next-state and slot load control (main + skid)
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_pay;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            state_nxt = ST_TWO;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Registered in_ready breaks the out_ready -> in_ready path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_nxt != ST_TWO);
    end
  end

`else

  assign in_ready = !out_valid || out_ready;

  // Occupancy next-state and load control (single register)
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_d    = in_pay;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

`endif

  // Occupancy state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating stall counter; clear wins, flush leaves it alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 8;
  localparam int unsigned SCW  = 4;
  localparam int          SMAX = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAP  = 2;
`else
  localparam int          CAP  = 1;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [CW-1:0]  in_ctrl;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_ctrl;
  logic [SCW-1:0] stall_cnt;
  logic           stall_clr;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of accepted payloads with capacity CAP, plus a stall tally
  logic [CW+DW-1:0] mq[$];
  int               mcnt;

  function automatic bit m_in_ready();
    if (CAP == 2) return (mq.size() < 2);
    return (mq.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit ov;
    bit ir;
    if (!reset_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      ov = (mq.size() > 0);
      ir = m_in_ready();
      if (stall_clr) mcnt = 0;
      else if (ov && !out_ready && mcnt < SMAX) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back({in_ctrl, in_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_out_ctrl", 64'(out_ctrl), 64'(mq[0][CW+DW-1:DW]));
      chk("m_out_data", 64'(out_data), 64'(mq[0][DW-1:0]));
    end else begin
      chk("m_out_ctrl", 64'(out_ctrl), 64'(0));
    end
    chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    chk("m_in_ready", 64'(in_ready), 64'(m_in_ready()));
  end

  // One cycle: report whether an input transfer happens at the coming edge
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int d;
    int guard;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    in_ctrl = 8'hFF; out_ready = 1'b0; stall_clr = 1'b0;

    // Reset held with live input
    repeat (3) step(acc);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back streaming, one-cycle latency
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = DW'(k); in_ctrl = CW'(k);
      step(acc);
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_data", 64'(out_data), 64'(k));
    end
    in_valid = 1'b0;
    step(acc);
    chk("stream_drain", 64'(out_valid), 64'(0));

    // Backpressure for five cycles mid-stream
    stall_clr = 1'b1; d = 100; in_valid = 1'b1; in_data = DW'(d); in_ctrl = CW'(d);
    step(acc);
    if (acc) d++;
    stall_clr = 1'b0; out_ready = 1'b0; in_data = DW'(d); in_ctrl = CW'(d);
    for (int i = 0; i < 5; i++) begin
      step(acc);
      if (acc) d++;
      in_data = DW'(d); in_ctrl = CW'(d);
      chk("bp_frozen", 64'(out_data), 64'(100));
    end
    chk("bp_stall_cnt", 64'(stall_cnt), 64'(5));
    out_ready = 1'b1;
    guard = 0;
    while (d <= 108 && guard < 50) begin
      step(acc);
      if (acc) d++;
      in_data = DW'(d); in_ctrl = CW'(d);
      guard++;
    end
    chk("bp_progress", 64'(guard < 50), 64'(1));
    in_valid = 1'b0;
    repeat (3) step(acc);
    chk("bp_drain", 64'(out_valid), 64'(0));

    // Flush with a simultaneous input that must be discarded
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'hA5;
    step(acc);
    chk("fl_hold_ctrl", 64'(out_ctrl), 64'(8'hA5));
    flush = 1'b1; in_data = 32'h1234; in_ctrl = 8'h3C;
    step(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_out_ctrl", 64'(out_ctrl), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("fl_no_valid", 64'(out_valid), 64'(0));
      chk("fl_no_1234", 64'(out_data == 32'h1234), 64'(0));
    end

    // Stall counter saturation and clear
    stall_clr = 1'b1;
    step(acc);
    stall_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7; in_ctrl = 8'h11;
    step(acc);
    in_valid = 1'b0;
    repeat (20) step(acc);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'(4'hF));
    stall_clr = 1'b1;
    step(acc);
    stall_clr = 1'b0;
    chk("clr_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("hold_valid", 64'(out_valid), 64'(1));

    // Asynchronous reset between edges while holding
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_ctrl", 64'(out_ctrl), 64'(0));
    #1 reset_n = 1'b1;
    step(acc);
    step(acc);
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_stay_empty", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
